// File: rtl/bomberman_pkg.sv
// Shared types and screen/tile geometry for the bomberman game logic.
package bomberman_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    BLAST    = 2'd2,
    COOLDOWN = 2'd3
  } bomb_state_t;

  localparam int unsigned TILE_SHIFT = 4;
  localparam int unsigned SCREEN_W   = 640;
  localparam int unsigned SCREEN_H   = 480;
  localparam int unsigned POS_W      = 10;
  localparam int unsigned EXT_W      = POS_W + 1;

  // Inclusive pixel extents of the blast cross handed to the renderer.
  typedef struct packed {
    logic [POS_W-1:0] x_min;
    logic [POS_W-1:0] x_max;
    logic [POS_W-1:0] y_min;
    logic [POS_W-1:0] y_max;
  } blast_ext_t;

  function automatic logic [EXT_W-1:0] clamp_max(input logic [EXT_W-1:0] v,
                                                 input logic [EXT_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/bomb_blast_check.sv
// Tile-distance hit test: is (px,py) on the blast cross of a bomb at (bx,by)?
module bomb_blast_check #(
  parameter int unsigned TW    = 7,
  parameter int unsigned RANGE = 2
) (
  input  logic [TW-1:0] bx_i,
  input  logic [TW-1:0] by_i,
  input  logic [TW-1:0] px_i,
  input  logic [TW-1:0] py_i,
  output logic          hit_o
);

  logic [TW-1:0] dx_c;
  logic [TW-1:0] dy_c;

  always_comb begin
    dx_c  = (px_i >= bx_i) ? (px_i - bx_i) : (bx_i - px_i);
    dy_c  = (py_i >= by_i) ? (py_i - by_i) : (by_i - py_i);
    hit_o = ((px_i == bx_i) && (32'(dy_c) <= RANGE)) ||
            ((py_i == by_i) && (32'(dx_c) <= RANGE));
  end

endmodule

// File: rtl/bomb_controller.sv
// Bomb lifecycle for one player: drop accept, tile snap, fuse/blast/cooldown,
// blast extents for the renderer, and single-hit damage with a heart counter.
module bomb_controller
  import bomberman_pkg::*;
#(
  parameter int unsigned FUSE_FRAMES     = 120,
  parameter int unsigned BLAST_FRAMES    = 30,
  parameter int unsigned COOLDOWN_FRAMES = 15,
  parameter int unsigned RANGE           = 2,
  parameter int unsigned HEARTS_INIT     = 3
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       bomb_drop,
  input  logic [9:0] userX,
  input  logic [9:0] userY,
  input  logic [9:0] userS,
  output logic       drop_ack,
  output logic       bomb_active,
  output logic       exploding,
  output logic [9:0] bombX,
  output logic [9:0] bombY,
  output logic [9:0] blast_x_min,
  output logic [9:0] blast_x_max,
  output logic [9:0] blast_y_min,
  output logic [9:0] blast_y_max,
  output logic       damage,
  output logic [2:0] heart,
  output logic       game_over
);

  localparam int unsigned TILE  = 1 << TILE_SHIFT;
  localparam int unsigned REACH = RANGE << TILE_SHIFT;
  localparam int unsigned TW    = EXT_W - TILE_SHIFT;

  bomb_state_t      state_q;
  logic [7:0]       cnt_q;
  logic             drop_prev_q;
  logic             drop_ack_q;
  logic             bomb_active_q;
  logic             exploding_q;
  logic [POS_W-1:0] bomb_x_q;
  logic [POS_W-1:0] bomb_y_q;
  blast_ext_t       ext_q;
  blast_ext_t       ext_d;
  logic             damage_q;
  logic [2:0]       heart_q;
  logic             game_over_q;
  logic             hit_done_q;

  logic             drop_edge_c;
  logic [EXT_W-1:0] cx_c;
  logic [EXT_W-1:0] cy_c;
  logic [POS_W-1:0] snap_x_c;
  logic [POS_W-1:0] snap_y_c;
  logic [EXT_W-1:0] bx_ext_c;
  logic [EXT_W-1:0] by_ext_c;
  logic [TW-1:0]    bomb_tx_c;
  logic [TW-1:0]    bomb_ty_c;
  logic [TW-1:0]    user_tx_c;
  logic [TW-1:0]    user_ty_c;
  logic             hit_c;

  assign drop_edge_c = bomb_drop & ~drop_prev_q;

  // Player centre in 11 bits so userX + userS/2 cannot wrap.
  assign cx_c     = EXT_W'(userX) + EXT_W'(userS >> 1);
  assign cy_c     = EXT_W'(userY) + EXT_W'(userS >> 1);
  assign snap_x_c = POS_W'(cx_c & ~EXT_W'(TILE - 1));
  assign snap_y_c = POS_W'(cy_c & ~EXT_W'(TILE - 1));

  assign bx_ext_c  = EXT_W'(bomb_x_q);
  assign by_ext_c  = EXT_W'(bomb_y_q);
  assign bomb_tx_c = TW'(bx_ext_c >> TILE_SHIFT);
  assign bomb_ty_c = TW'(by_ext_c >> TILE_SHIFT);
  assign user_tx_c = TW'(cx_c >> TILE_SHIFT);
  assign user_ty_c = TW'(cy_c >> TILE_SHIFT);

  // Cross extents: low side floors at 0, high side clamps to the last screen pixel.
  always_comb begin
    ext_d       = '0;
    ext_d.x_min = (bx_ext_c >= EXT_W'(REACH)) ? POS_W'(bx_ext_c - EXT_W'(REACH)) : '0;
    ext_d.y_min = (by_ext_c >= EXT_W'(REACH)) ? POS_W'(by_ext_c - EXT_W'(REACH)) : '0;
    ext_d.x_max = POS_W'(clamp_max(bx_ext_c + EXT_W'(REACH + TILE - 1), EXT_W'(SCREEN_W - 1)));
    ext_d.y_max = POS_W'(clamp_max(by_ext_c + EXT_W'(REACH + TILE - 1), EXT_W'(SCREEN_H - 1)));
  end

  bomb_blast_check #(
    .TW   (TW),
    .RANGE(RANGE)
  ) u_blast_check (
    .bx_i (bomb_tx_c),
    .by_i (bomb_ty_c),
    .px_i (user_tx_c),
    .py_i (user_ty_c),
    .hit_o(hit_c)
  );

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      drop_prev_q   <= 1'b1;
      drop_ack_q    <= 1'b0;
      bomb_active_q <= 1'b0;
      exploding_q   <= 1'b0;
      bomb_x_q      <= '0;
      bomb_y_q      <= '0;
      ext_q         <= '0;
      damage_q      <= 1'b0;
      heart_q       <= 3'(HEARTS_INIT);
      game_over_q   <= 1'b0;
      hit_done_q    <= 1'b0;
    end else begin
      drop_prev_q <= bomb_drop;
      drop_ack_q  <= 1'b0;
      damage_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (drop_edge_c && !game_over_q) begin
            state_q       <= ARMED;
            cnt_q         <= 8'(FUSE_FRAMES - 1);
            drop_ack_q    <= 1'b1;
            bomb_active_q <= 1'b1;
            bomb_x_q      <= snap_x_c;
            bomb_y_q      <= snap_y_c;
          end
        end
        ARMED: begin
          if (cnt_q == 8'd0) begin
            state_q     <= BLAST;
            cnt_q       <= 8'(BLAST_FRAMES - 1);
            exploding_q <= 1'b1;
            ext_q       <= ext_d;
            hit_done_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        BLAST: begin
          // One hit per bomb; the last BLAST cycle still counts.
          if (hit_c && !hit_done_q) begin
            damage_q   <= 1'b1;
            hit_done_q <= 1'b1;
            if (heart_q != 3'd0) heart_q <= heart_q - 3'd1;
            if (heart_q == 3'd1) game_over_q <= 1'b1;
          end
          if (cnt_q == 8'd0) begin
            state_q       <= COOLDOWN;
            cnt_q         <= 8'(COOLDOWN_FRAMES - 1);
            exploding_q   <= 1'b0;
            bomb_active_q <= 1'b0;
            ext_q         <= '0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        COOLDOWN: begin
          if (cnt_q == 8'd0) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign drop_ack    = drop_ack_q;
  assign bomb_active = bomb_active_q;
  assign exploding   = exploding_q;
  assign bombX       = bomb_x_q;
  assign bombY       = bomb_y_q;
  assign blast_x_min = ext_q.x_min;
  assign blast_x_max = ext_q.x_max;
  assign blast_y_min = ext_q.y_min;
  assign blast_y_max = ext_q.y_max;
  assign damage      = damage_q;
  assign heart       = heart_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_bomb_controller.sv
// Bench for bomb_controller: directed lifecycle cases plus randomized player movement
// checked against a tile-level model of hits, hearts and blast extents.
module tb_bomb_controller;

  localparam int FUSE  = 4;
  localparam int BLST  = 3;
  localparam int COOL  = 2;
  localparam int RNG   = 2;
  localparam int TPX   = 16;
  localparam int HINIT = 3;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic       bomb_drop;
  logic [9:0] userX, userY, userS;
  logic       drop_ack, bomb_active, exploding, damage, game_over;
  logic [9:0] bombX, bombY, blast_x_min, blast_x_max, blast_y_min, blast_y_max;
  logic [2:0] heart;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_heart;
  bit exp_go;

  bomb_controller #(
    .FUSE_FRAMES    (FUSE),
    .BLAST_FRAMES   (BLST),
    .COOLDOWN_FRAMES(COOL),
    .RANGE          (RNG),
    .HEARTS_INIT    (HINIT)
  ) dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .bomb_drop  (bomb_drop),
    .userX      (userX),
    .userY      (userY),
    .userS      (userS),
    .drop_ack   (drop_ack),
    .bomb_active(bomb_active),
    .exploding  (exploding),
    .bombX      (bombX),
    .bombY      (bombY),
    .blast_x_min(blast_x_min),
    .blast_x_max(blast_x_max),
    .blast_y_min(blast_y_min),
    .blast_y_max(blast_y_max),
    .damage     (damage),
    .heart      (heart),
    .game_over  (game_over)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  // Put the player so its centre lands on pixel (cx,cy).
  task automatic place(input int cx, input int cy, input int us);
    userS = 10'(us);
    userX = 10'(cx - us / 2);
    userY = 10'(cy - us / 2);
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit model_hit(input int dx, input int dy);
    return (dx == 0 && iabs(dy) <= RNG) || (dy == 0 && iabs(dx) <= RNG);
  endfunction

  task automatic do_reset();
    Reset     = 1'b1;
    bomb_drop = 1'b1;
    tick();
    Reset = 1'b0;
    check("rst_heart", int'(heart), HINIT);
    check("rst_go", int'(game_over), 0);
    check("rst_active", int'(bomb_active), 0);
    check("rst_expl", int'(exploding), 0);
    check("rst_bombx", int'(bombX), 0);
    check("rst_xmax", int'(blast_x_max), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rst_held_noack", int'(drop_ack), 0);
    end
    bomb_drop = 1'b0;
    tick();
    exp_heart = HINIT;
    exp_go    = 1'b0;
  endtask

  // One bomb from drop edge to IDLE; fixed selects the blast-phase player tile offset.
  task automatic run_bomb(input string nm, input int cx, input int cy, input int us,
                          input bit fixed, input int fdx, input int fdy);
    int btx, bty, bxp, byp, first_hit, dx, dy;
    int ex_xmin, ex_xmax, ex_ymin, ex_ymax;
    bit blast_now;
    btx = cx / TPX;
    bty = cy / TPX;
    bxp = btx * TPX;
    byp = bty * TPX;
    first_hit = -1;
    ex_xmin = (bxp >= RNG * TPX) ? bxp - RNG * TPX : 0;
    ex_ymin = (byp >= RNG * TPX) ? byp - RNG * TPX : 0;
    ex_xmax = (bxp + (RNG + 1) * TPX - 1 > 639) ? 639 : bxp + (RNG + 1) * TPX - 1;
    ex_ymax = (byp + (RNG + 1) * TPX - 1 > 479) ? 479 : byp + (RNG + 1) * TPX - 1;
    place(cx, cy, us);
    bomb_drop = 1'b1;
    tick();
    if (exp_go) begin
      for (int j = 0; j < 10; j++) begin
        check({nm, "_go_noack"}, int'(drop_ack), 0);
        check({nm, "_go_inactive"}, int'(bomb_active), 0);
        check({nm, "_go_sticky"}, int'(game_over), 1);
        check({nm, "_go_heart"}, int'(heart), 0);
        bomb_drop = 1'($urandom_range(0, 1));
        tick();
      end
      bomb_drop = 1'b0;
      tick();
      return;
    end
    for (int j = 0; j < 10; j++) begin
      blast_now = (j >= FUSE) && (j < FUSE + BLST);
      check({nm, "_ack"}, int'(drop_ack), int'(j == 0));
      check({nm, "_active"}, int'(bomb_active), int'(j < FUSE + BLST));
      check({nm, "_expl"}, int'(exploding), int'(blast_now));
      check({nm, "_damage"}, int'(damage), int'(first_hit >= 0 && j == first_hit + 1));
      check({nm, "_heart"}, int'(heart), exp_heart);
      check({nm, "_go"}, int'(game_over), int'(exp_go));
      check({nm, "_bombx"}, int'(bombX), bxp);
      check({nm, "_bomby"}, int'(bombY), byp);
      check({nm, "_xmin"}, int'(blast_x_min), blast_now ? ex_xmin : 0);
      check({nm, "_xmax"}, int'(blast_x_max), blast_now ? ex_xmax : 0);
      check({nm, "_ymin"}, int'(blast_y_min), blast_now ? ex_ymin : 0);
      check({nm, "_ymax"}, int'(blast_y_max), blast_now ? ex_ymax : 0);
      // Late-phase drop pattern ends with an edge on the COOLDOWN->IDLE cycle.
      if (j < FUSE + BLST) bomb_drop = 1'($urandom_range(0, 1));
      else bomb_drop = (j == FUSE + BLST + COOL - 1);
      if (blast_now) begin
        dx = fixed ? fdx : int'($urandom_range(0, 6)) - 3;
        dy = fixed ? fdy : int'($urandom_range(0, 6)) - 3;
        place((btx + dx) * TPX + int'($urandom_range(8, 15)),
              (bty + dy) * TPX + int'($urandom_range(8, 15)), int'($urandom_range(0, 14)));
        if (first_hit < 0 && model_hit(dx, dy)) begin
          first_hit = j;
          if (exp_heart > 0) exp_heart--;
          if (exp_heart == 0) exp_go = 1'b1;
        end
      end else begin
        place(bxp + int'($urandom_range(8, 15)), byp + int'($urandom_range(8, 15)),
              int'($urandom_range(0, 14)));
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks, cx, cy;
    Reset     = 1'b1;
    bomb_drop = 1'b0;
    userX     = '0;
    userY     = '0;
    userS     = '0;
    exp_heart = HINIT;
    exp_go    = 1'b0;

    do_reset();
    run_bomb("basic", 104, 104, 8, 1'b1, 3, 0);

    place(200, 200, 8);
    bomb_drop = 1'b1;
    acks = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (drop_ack) acks++;
      if (k == 0) place(248, 248, 8);
    end
    check("hold_one_ack", acks, 1);
    check("hold_heart", int'(heart), exp_heart);
    bomb_drop = 1'b0;
    tick();

    run_bomb("hit_p2x", 300, 200, 8, 1'b1, 2, 0);
    run_bomb("miss_p3x", 300, 200, 6, 1'b1, 3, 0);
    run_bomb("miss_diag", 300, 200, 4, 1'b1, 1, 1);
    run_bomb("corner_lo", 4, 4, 8, 1'b1, 3, 0);
    run_bomb("corner_hi", 628, 468, 8, 1'b1, -3, 0);
    run_bomb("hit_m2y", 200, 300, 8, 1'b1, 0, -2);
    run_bomb("hit_m2x", 200, 300, 8, 1'b1, -2, 0);
    check("three_hits_go", int'(game_over), 1);
    run_bomb("after_go", 200, 200, 8, 1'b0, 0, 0);

    do_reset();
    place(300, 300, 8);
    bomb_drop = 1'b1;
    tick();
    check("mid_ack", int'(drop_ack), 1);
    bomb_drop = 1'b0;
    for (int k = 0; k < FUSE + 1; k++) tick();
    check("mid_expl", int'(exploding), 1);
    check("mid_dmg_heart", int'(heart), HINIT - 1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("mid_rst_expl", int'(exploding), 0);
    check("mid_rst_active", int'(bomb_active), 0);
    check("mid_rst_heart", int'(heart), HINIT);
    check("mid_rst_go", int'(game_over), 0);
    check("mid_rst_xmin", int'(blast_x_min), 0);
    check("mid_rst_dmg", int'(damage), 0);
    tick();
    exp_heart = HINIT;
    exp_go    = 1'b0;

    for (int i = 0; i < 24; i++) begin
      cx = int'($urandom_range(3, 36)) * TPX + int'($urandom_range(8, 15));
      cy = int'($urandom_range(3, 26)) * TPX + int'($urandom_range(8, 15));
      run_bomb("rnd", cx, cy, int'($urandom_range(0, 14)), 1'b0, 0, 0);
      if (exp_go) begin
        run_bomb("rnd_go", cx, cy, 8, 1'b0, 0, 0);
        do_reset();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
